audio_tone_gen: RTL and testbench

Square-wave tone synthesiser with a linear volume envelope and 1-bit PWM output. It sits directly downstream of the top level and consumes the processor's audioVol/audioSel/audioEn outputs. It drives the board's audio pin through an external RC filter. Note changes are glitch-free, and volume ramps on attack and release to avoid clicks.

---
 rtl/audio_tone_gen.sv | 189 ++++++++++++++++++
 tb/tb_audio_tone_gen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_tone_gen.sv
// ---------------------------------------------------------------------------
// audio_tone_gen
//   Square-wave tone synthesiser with a linear volume envelope and a 1-bit
//   PWM output intended to feed an external RC filter.
//
//   A prescaler produces a tick every PRESCALE clocks. The square wave's
//   half-period is (16 - note) * HP_STEP ticks. Note changes take effect only
//   at a square edge, so the waveform never glitches. The envelope level
//   steps by one every ENV_DIV ticks: toward audioVol while playing, and down
//   to zero on release.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   audioVol     target volume 0..31
//   audioSel     note index, 0 = rest, 1..15 = tone
//   audioEn      play request (level-sensitive)
//   audio_pwm    PWM audio output (registered)
//   audio_busy   high whenever the generator is not idle
//   audio_level  current envelope level
// ---------------------------------------------------------------------------
module audio_tone_gen #(
   parameter int PRESCALE = 16,
   parameter int HP_STEP  = 8,
   parameter int ENV_DIV  = 64
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] audioVol,
   input  logic [3:0] audioSel,
   input  logic       audioEn,
   output logic       audio_pwm,
   output logic       audio_busy,
   output logic [4:0] audio_level
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PLAY    = 2'd1,
      S_RELEASE = 2'd2
   } state_t;

   localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int ENV_W = (ENV_DIV > 1) ? $clog2(ENV_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
   localparam logic [ENV_W-1:0] ENV_LAST = ENV_W'(ENV_DIV - 1);

   // Half-period in ticks for a note index, truncated to 16 bits.
   function automatic logic [15:0] half_of(input logic [3:0] sel);
      return 16'((32'd16 - 32'(sel)) * 32'(HP_STEP));
   endfunction

   state_t           state_q, state_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [ENV_W-1:0] env_q, env_d;
   logic [15:0]      phase_q, phase_d;
   logic [3:0]       sel_q, sel_d;
   logic             square_q, square_d;
   logic [4:0]       level_q, level_d;
   logic             entry_q, entry_d;
   logic [4:0]       frame_q, frame_d;
   logic [4:0]       duty_q, duty_d;
   logic             pwm_q, pwm_d;

   logic        tick;
   logic        env_wrap;
   logic        edge_hit;
   logic        req;
   logic [15:0] half;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         pre_q    <= '0;
         env_q    <= '0;
         phase_q  <= '0;
         sel_q    <= '0;
         square_q <= 1'b0;
         level_q  <= '0;
         entry_q  <= 1'b0;
         frame_q  <= '0;
         duty_q   <= '0;
         pwm_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pre_q    <= pre_d;
         env_q    <= env_d;
         phase_q  <= phase_d;
         sel_q    <= sel_d;
         square_q <= square_d;
         level_q  <= level_d;
         entry_q  <= entry_d;
         frame_q  <= frame_d;
         duty_q   <= duty_d;
         pwm_q    <= pwm_d;
      end
   end

   always_comb begin
      tick     = (pre_q == PRE_LAST);
      pre_d    = tick ? '0 : pre_q + PRE_W'(1);
      req      = audioEn & (audioSel != 4'd0);
      half     = half_of(sel_q);
      env_wrap = tick & (env_q == ENV_LAST);
      edge_hit = tick & (phase_q == half - 16'd1);

      // PWM: duty is captured on the last slot of a frame so a level change
      // never alters a frame already in progress.
      frame_d = frame_q + 5'd1;
      duty_d  = (frame_q == 5'd31) ? level_q : duty_q;
      pwm_d   = square_q & (frame_q < duty_q);

      state_d  = state_q;
      env_d    = env_q;
      phase_d  = phase_q;
      sel_d    = sel_q;
      square_d = square_q;
      level_d  = level_q;
      entry_d  = 1'b0;

      // Oscillator and envelope timebase run identically in PLAY and RELEASE.
      if (state_q != S_IDLE) begin
         if (tick) begin
            env_d = env_wrap ? '0 : env_q + ENV_W'(1);
         end
         if (edge_hit) begin
            phase_d  = '0;
            square_d = ~square_q;
         end else if (tick) begin
            phase_d = phase_q + 16'd1;
         end
      end

      case (state_q)
         S_IDLE: begin
            env_d    = '0;
            phase_d  = '0;
            square_d = 1'b0;
            level_d  = '0;
            if (req) begin
               state_d  = S_PLAY;
               sel_d    = audioSel;
               square_d = 1'b1;
            end
         end
         S_PLAY: begin
            // New notes are only adopted at a square edge.
            if (edge_hit && (audioSel != 4'd0)) begin
               sel_d = audioSel;
            end
            if (env_wrap) begin
               if (level_q < audioVol) begin
                  level_d = level_q + 5'd1;
               end else if (level_q > audioVol) begin
                  level_d = level_q - 5'd1;
               end
            end
            if (!req) begin
               state_d = S_RELEASE;
               entry_d = 1'b1;
            end
         end
         S_RELEASE: begin
            // Going idle takes priority over a re-trigger in the same cycle.
            if ((level_q == 5'd0) && (env_wrap || entry_q)) begin
               state_d  = S_IDLE;
               square_d = 1'b0;
               phase_d  = '0;
               env_d    = '0;
            end else begin
               if (env_wrap) begin
                  level_d = level_q - 5'd1;
               end
               if (req) begin
                  state_d = S_PLAY;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign audio_pwm   = pwm_q;
   assign audio_busy  = (state_q != S_IDLE);
   assign audio_level = level_q;

endmodule

// File: tb/tb_audio_tone_gen.sv
// ---------------------------------------------------------------------------
// tb_audio_tone_gen
//   Two instances with different timing parameters share one set of inputs.
//   Each is compared every cycle against a behavioural model built from the
//   tone/envelope/PWM rules, with directed scenarios followed by random play.
// ---------------------------------------------------------------------------
module tb_audio_tone_gen;

   localparam int PA = 1, HA = 2,  EA = 4;
   localparam int PB = 1, HB = 16, EB = 1;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] vol;
   logic [3:0] sel;
   logic       en;
   logic       pwm_a, busy_a, pwm_b, busy_b;
   logic [4:0] lvl_a, lvl_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   audio_tone_gen #(.PRESCALE(PA), .HP_STEP(HA), .ENV_DIV(EA)) dut_a (
      .clk(clk), .reset(reset), .audioVol(vol), .audioSel(sel), .audioEn(en),
      .audio_pwm(pwm_a), .audio_busy(busy_a), .audio_level(lvl_a));

   audio_tone_gen #(.PRESCALE(PB), .HP_STEP(HB), .ENV_DIV(EB)) dut_b (
      .clk(clk), .reset(reset), .audioVol(vol), .audioSel(sel), .audioEn(en),
      .audio_pwm(pwm_b), .audio_busy(busy_b), .audio_level(lvl_b));

   // Behavioural model: st 0 = idle, 1 = playing, 2 = releasing.
   typedef struct {
      int st;
      int pre;
      int env;
      int phase;
      int note;
      int sq;
      int lvl;
      int entry;
      int frame;
      int duty;
      int pwm;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mdl_zero();
      mdl_t z;
      z = '{default: 0};
      return z;
   endfunction

   function automatic mdl_t mdl_next(mdl_t m, int p, int h, int e,
                                     int v, int s, int enable);
      mdl_t n;
      bit   tick, wrap, req;
      int   half;
      n    = m;
      tick = (m.pre == p - 1);
      wrap = tick && (m.env == e - 1);
      req  = (enable != 0) && (s != 0);
      half = ((16 - m.note) * h) % 65536;
      n.pre   = tick ? 0 : m.pre + 1;
      n.frame = (m.frame + 1) % 32;
      if (m.frame == 31) n.duty = m.lvl;
      n.pwm   = (m.sq != 0 && m.frame < m.duty) ? 1 : 0;
      n.entry = 0;
      if (m.st == 0) begin
         n.env = 0; n.phase = 0; n.sq = 0; n.lvl = 0;
         if (req) begin
            n.st = 1; n.note = s; n.sq = 1;
         end
         return n;
      end
      if (tick) begin
         n.env = (m.env + 1) % e;
         if (m.phase == (half + 65535) % 65536) begin
            n.phase = 0;
            n.sq    = 1 - m.sq;
            if (m.st == 1 && s != 0) n.note = s;
         end else begin
            n.phase = m.phase + 1;
         end
      end
      if (m.st == 1) begin
         if (wrap) begin
            if (v > m.lvl) n.lvl = m.lvl + 1;
            else if (v < m.lvl) n.lvl = m.lvl - 1;
         end
         if (!req) begin
            n.st = 2; n.entry = 1;
         end
      end else begin
         if (m.lvl == 0 && (wrap || m.entry != 0)) begin
            n.st = 0; n.sq = 0; n.phase = 0; n.env = 0;
         end else begin
            if (wrap) n.lvl = m.lvl - 1;
            if (req) n.st = 1;
         end
      end
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      chk("a_pwm",   32'(pwm_a),  ma.pwm);
      chk("a_busy",  32'(busy_a), (ma.st != 0) ? 1 : 0);
      chk("a_level", 32'(lvl_a),  ma.lvl);
      chk("b_pwm",   32'(pwm_b),  mb.pwm);
      chk("b_busy",  32'(busy_b), (mb.st != 0) ? 1 : 0);
      chk("b_level", 32'(lvl_b),  mb.lvl);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         ma = mdl_next(ma, PA, HA, EA, int'(vol), int'(sel), int'(en));
         mb = mdl_next(mb, PB, HB, EB, int'(vol), int'(sel), int'(en));
         #1;
         compare_all();
      end
   endtask

   // Asserted between clock edges; outputs must clear without a clock.
   task automatic do_reset();
      #2;
      reset = 1'b1;
      #1;
      chk("rst_async_level", 32'(lvl_a),  0);
      chk("rst_async_busy",  32'(busy_a), 0);
      chk("rst_async_pwm",   32'(pwm_a),  0);
      ma = mdl_zero();
      mb = mdl_zero();
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int hi;
      reset = 1'b1;
      en    = 1'b0;
      sel   = 4'd0;
      vol   = 5'd0;
      #12;
      chk("rst_level", 32'(lvl_a), 0);
      chk("rst_busy",  32'(busy_b), 0);
      chk("rst_pwm",   32'(pwm_a), 0);
      ma = mdl_zero();
      mb = mdl_zero();
      #5;
      reset = 1'b0;

      // Reset mid-frame, then stay idle.
      step(13);
      do_reset();
      step(200);
      chk("idle_busy",  32'(busy_a), 0);
      chk("idle_level", 32'(lvl_b), 0);

      // Note start and full-scale attack.
      vol = 5'd31; sel = 4'd14; en = 1'b1;
      step(1);
      chk("start_busy_a", 32'(busy_a), 1);
      chk("start_busy_b", 32'(busy_b), 1);
      step(30);
      chk("b_level_30", 32'(lvl_b), 30);
      step(1);
      chk("b_level_31", 32'(lvl_b), 31);
      chk("a_level_7",  32'(lvl_a), 7);
      step(100);

      // Note change two ticks into a half-period.
      n = 0;
      while (ma.phase != 2 && n < 20) begin
         step(1);
         n++;
      end
      chk("note_chg_phase", 32'(n < 20), 1);
      sel = 4'd12;
      step(60);

      // Attack to 8 and release.
      do_reset();
      vol = 5'd8; sel = 4'd14; en = 1'b1;
      step(32);
      chk("attack_7", 32'(lvl_a), 7);
      step(1);
      chk("attack_8", 32'(lvl_a), 8);
      step(8);
      en = 1'b0;
      n = 0;
      while (lvl_a != 5'd0 && n < 200) begin
         step(1);
         n++;
      end
      chk("release_len", n, 32);
      while (busy_a && n < 200) begin
         step(1);
         n++;
      end
      chk("release_idle", n, 36);
      chk("release_busy", 32'(busy_a), 0);

      // Re-trigger during release.
      do_reset();
      vol = 5'd8; sel = 4'd14; en = 1'b1;
      step(33);
      en = 1'b0;
      n = 0;
      while (lvl_a != 5'd5 && n < 100) begin
         step(1);
         n++;
      end
      chk("retrig_at5", 32'(lvl_a), 5);
      en = 1'b1;
      step(1);
      chk("retrig_busy",  32'(busy_a), 1);
      chk("retrig_level", 32'(lvl_a), 5);
      step(40);
      chk("retrig_ramp", 32'(lvl_a), 8);

      // PWM duty with the square held high on the long note.
      do_reset();
      vol = 5'd16; sel = 4'd1; en = 1'b1;
      step(70);
      hi = 0;
      for (int i = 0; i < 32; i++) begin
         step(1);
         hi += int'(pwm_b);
      end
      chk("duty_16", hi, 16);
      n = 0;
      while (mb.frame != 10 && n < 40) begin
         step(1);
         n++;
      end
      vol = 5'd20;
      step(40);
      hi = 0;
      for (int i = 0; i < 32; i++) begin
         step(1);
         hi += int'(pwm_b);
      end
      chk("duty_20", hi, 20);

      // Random play.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) en = ~en;
         if ($urandom_range(0, 29) == 0) sel = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 49) == 0) vol = 5'($urandom_range(0, 31));
         if ($urandom_range(0, 1499) == 0) do_reset();
         step(1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
